// File: rtl/cpu_branch_predictor.sv
// cpu_branch_predictor
//
// Fetch-stage branch target buffer. Each entry holds a direction counter.
// Lookup is purely combinational from the registered table. Execute trains
// the table through the update port, and the new contents become visible
// on the following edge. There is no bypass from upd_* to the lookup outputs.
//
// Configuration macro: CPU_BP_HYSTERESIS_EN
//   defined   - each entry has a 2-bit saturating direction counter
//   undefined - each entry keeps 1 bit, the last resolved outcome
//
// Ports
//   clk, rst        clock; synchronous active-high reset (clears valid bits)
//   flush           invalidate every entry on the next edge; drops the update
//   lookup_pc       fetch PC to look up
//   pred_taken      predicted redirect for lookup_pc
//   target_hit      valid entry whose tag matches lookup_pc
//   target_addr     stored target on a hit, else 0
//   upd_valid       resolved control-flow instruction this cycle
//   upd_pc          PC of the resolved instruction
//   upd_is_jump     JAL/JALR; takes priority over upd_is_branch
//   upd_is_branch   conditional branch
//   upd_taken       resolved branch direction; ignored for jumps
//   upd_target      resolved target address

module cpu_branch_predictor #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic            target_hit,
    output logic [XLEN-1:0] target_addr,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_is_branch,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TagW = XLEN - IDX - 2;

`ifdef CPU_BP_HYSTERESIS_EN
    localparam int unsigned  CtrW     = 2;
    localparam logic [1:0]   CtrMax   = 2'b11;
    localparam logic [1:0]   CtrAlloc = 2'b10;
`else
    localparam int unsigned  CtrW     = 1;
    localparam logic [0:0]   CtrMax   = 1'b1;
    localparam logic [0:0]   CtrAlloc = 1'b1;
`endif

    // Table storage. Only the valid bits are reset.
    logic [ENTRIES-1:0] valid_q;
    logic [TagW-1:0]    tag_q     [ENTRIES];
    logic [XLEN-1:0]    target_q  [ENTRIES];
    logic               is_jump_q [ENTRIES];
    logic [CtrW-1:0]    ctr_q     [ENTRIES];

    // PC bits [1:0] carry no information for the index or the tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [IDX-1:0]  lk_idx;
    logic [TagW-1:0] lk_tag;

    always_comb begin
        lk_idx      = lookup_pc[IDX+1:2];
        lk_tag      = lookup_pc[XLEN-1:IDX+2];
        target_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = target_hit && (is_jump_q[lk_idx] || ctr_q[lk_idx][CtrW-1]);
        target_addr = target_hit ? target_q[lk_idx] : '0;
    end

    // ------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------
    logic [IDX-1:0]  upd_idx;
    logic [TagW-1:0] upd_tag;
    logic            upd_hit;
    logic            upd_ctrl;
    logic            wr_en;
    logic            alloc;
    logic [CtrW-1:0] ctr_cur;
    logic [CtrW-1:0] ctr_d;

    always_comb begin
        upd_idx  = upd_pc[IDX+1:2];
        upd_tag  = upd_pc[XLEN-1:IDX+2];
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_ctrl = upd_valid && (upd_is_jump || upd_is_branch);
        // A miss allocates for jumps and taken branches only.
        alloc    = !upd_hit && (upd_is_jump || upd_taken);
        // Reset and flush both drop any update in the same cycle.
        wr_en    = upd_ctrl && !flush && !rst && (upd_hit || alloc);
        ctr_cur  = ctr_q[upd_idx];
        ctr_d    = ctr_cur;

        if (upd_is_jump) begin
            ctr_d = CtrMax;
        end else if (!upd_hit) begin
            ctr_d = CtrAlloc;
        end else begin
`ifdef CPU_BP_HYSTERESIS_EN
            if (upd_taken) begin
                ctr_d = (ctr_cur == 2'b11) ? ctr_cur : ctr_cur + 2'd1;
            end else begin
                ctr_d = (ctr_cur == 2'b00) ? ctr_cur : ctr_cur - 2'd1;
            end
`else
            ctr_d = upd_taken;
`endif
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            target_q[upd_idx] <= upd_target;
            ctr_q[upd_idx]    <= ctr_d;
            // A hit keeps the entry's tag and type; only allocation replaces them.
            if (!upd_hit) begin
                tag_q[upd_idx]     <= upd_tag;
                is_jump_q[upd_idx] <= upd_is_jump;
            end
        end
    end

endmodule

// File: tb/tb_cpu_branch_predictor.sv
module tb_cpu_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic        target_hit;
    logic [31:0] target_addr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_is_branch;
    logic        upd_taken;
    logic [31:0] upd_target;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_branch_predictor #(
        .XLEN    (32),
        .ENTRIES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .lookup_pc     (lookup_pc),
        .pred_taken    (pred_taken),
        .target_hit    (target_hit),
        .target_addr   (target_addr),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_is_jump   (upd_is_jump),
        .upd_is_branch (upd_is_branch),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one update for a cycle, then release the port.
    task automatic do_update(input logic [31:0] pc, input logic jump, input logic branch,
                             input logic taken, input logic [31:0] tgt);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_is_jump   = jump;
        upd_is_branch = branch;
        upd_taken     = taken;
        upd_target    = tgt;
        @(posedge clk);
        #1;
        upd_valid     = 1'b0;
        upd_is_jump   = 1'b0;
        upd_is_branch = 1'b0;
        upd_taken     = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; lookup_pc = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_is_jump = 1'b0;
        upd_is_branch = 1'b0; upd_taken = 1'b0; upd_target = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        look(32'h100);
        check_eq("rst_hit",   {31'b0, target_hit}, 32'd0);
        check_eq("rst_taken", {31'b0, pred_taken}, 32'd0);
        check_eq("rst_addr",  target_addr, 32'h0);

        // Jump allocation
        do_update(32'h100, 1'b1, 1'b0, 1'b0, 32'h200);
        look(32'h100);
        check_eq("jmp_hit",   {31'b0, target_hit}, 32'd1);
        check_eq("jmp_taken", {31'b0, pred_taken}, 32'd1);
        check_eq("jmp_addr",  target_addr, 32'h200);
        look(32'h500);  // same index, different tag
        check_eq("alias_hit",   {31'b0, target_hit}, 32'd0);
        check_eq("alias_taken", {31'b0, pred_taken}, 32'd0);
        check_eq("alias_addr",  target_addr, 32'h0);

        // Same-cycle lookup and update returns pre-update contents
        lookup_pc     = 32'h100;
        upd_valid     = 1'b1;
        upd_pc        = 32'h100;
        upd_is_jump   = 1'b1;
        upd_target    = 32'h300;
        #1;
        check_eq("same_cyc_old", target_addr, 32'h200);
        @(posedge clk);
        #1;
        upd_valid   = 1'b0;
        upd_is_jump = 1'b0;
        #1;
        check_eq("same_cyc_new", target_addr, 32'h300);

        // Reset with an update in flight: update dropped, entry invalidated
        rst = 1'b1;
        do_update(32'h100, 1'b1, 1'b0, 1'b0, 32'h600);
        rst = 1'b0;
        look(32'h100);
        check_eq("rst_upd_hit", {31'b0, target_hit}, 32'd0);

        // Branch training at 0x40
        do_update(32'h40, 1'b0, 1'b1, 1'b1, 32'h20);
        look(32'h40);
        check_eq("br_alloc_hit",   {31'b0, target_hit}, 32'd1);
        check_eq("br_alloc_taken", {31'b0, pred_taken}, 32'd1);
        check_eq("br_alloc_addr",  target_addr, 32'h20);
        do_update(32'h40, 1'b0, 1'b1, 1'b0, 32'h20);
        look(32'h40);
        check_eq("br_nt1_taken", {31'b0, pred_taken}, 32'd0);
        check_eq("br_nt1_hit",   {31'b0, target_hit}, 32'd1);
`ifdef CPU_BP_HYSTERESIS_EN
        do_update(32'h40, 1'b0, 1'b1, 1'b0, 32'h20);  // ctr 0
        look(32'h40);
        check_eq("br_nt2_taken", {31'b0, pred_taken}, 32'd0);
        do_update(32'h40, 1'b0, 1'b1, 1'b1, 32'h20);  // ctr 1
        look(32'h40);
        check_eq("br_t1_taken", {31'b0, pred_taken}, 32'd0);
        do_update(32'h40, 1'b0, 1'b1, 1'b1, 32'h20);  // ctr 2
        look(32'h40);
        check_eq("br_t2_taken", {31'b0, pred_taken}, 32'd1);
`else
        do_update(32'h40, 1'b0, 1'b1, 1'b1, 32'h20);
        look(32'h40);
        check_eq("br_t1_taken", {31'b0, pred_taken}, 32'd1);
`endif

        // Non-control instruction never writes
        do_update(32'h40, 1'b0, 1'b0, 1'b1, 32'hdead);
        look(32'h40);
        check_eq("nonctl_addr", target_addr, 32'h20);

        // Not-taken branch at an unseen PC does not allocate
        do_update(32'h80, 1'b0, 1'b1, 1'b0, 32'h90);
        look(32'h80);
        check_eq("nt_miss_hit", {31'b0, target_hit}, 32'd0);
        look(32'h40);
        check_eq("nt_keep_hit", {31'b0, target_hit}, 32'd1);

        // Flush beats a same-cycle update
        flush = 1'b1;
        do_update(32'h140, 1'b1, 1'b0, 1'b0, 32'h400);
        flush = 1'b0;
        look(32'h140);
        check_eq("flush_upd_hit",  {31'b0, target_hit}, 32'd0);
        check_eq("flush_upd_addr", target_addr, 32'h0);
        look(32'h40);
        check_eq("flush_old_hit",  {31'b0, target_hit}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
